// File: rtl/hazard_scoreboard_if.sv
// Decode-side hazard bus: decode/pipeline status in, forwarding selects and pipeline control out.
// The unit connects through the slave modport and the decode driver through the master modport.
interface hazard_scoreboard_if #(
    parameter int XLEN       = 32,
    parameter int FWD_STAGES = 2
);
    localparam int SELW = $clog2(FWD_STAGES + 2);

    logic                      DE_VALID;
    logic [4:0]                RS1;
    logic [4:0]                RS2;
    logic                      RS1_USED;
    logic                      RS2_USED;
    logic [4:0]                RD;
    logic                      RD_WE;
    logic                      LONG_OP;
    logic [5*FWD_STAGES-1:0]   FWD_RD;
    logic [FWD_STAGES-1:0]     FWD_WE;
    logic [FWD_STAGES-1:0]     FWD_RDY;
    logic                      LU_DONE;
    logic [4:0]                LU_RD;
    logic                      BRANCH;
    logic [2:0]                BRANCH_TYPE;
    logic [XLEN-1:0]           BRANCH_ARG1;
    logic [XLEN-1:0]           BRANCH_ARG2;

    logic [SELW-1:0]           FWD_A_SEL;
    logic [SELW-1:0]           FWD_B_SEL;
    logic                      STALL;
    logic                      BRANCH_TAKEN;
    logic                      FLUSH;
    logic [31:0]               STALL_CYCLES;

    modport master (
        output DE_VALID, RS1, RS2, RS1_USED, RS2_USED, RD, RD_WE, LONG_OP,
        output FWD_RD, FWD_WE, FWD_RDY, LU_DONE, LU_RD,
        output BRANCH, BRANCH_TYPE, BRANCH_ARG1, BRANCH_ARG2,
        input  FWD_A_SEL, FWD_B_SEL, STALL, BRANCH_TAKEN, FLUSH, STALL_CYCLES
    );

    modport slave (
        input  DE_VALID, RS1, RS2, RS1_USED, RS2_USED, RD, RD_WE, LONG_OP,
        input  FWD_RD, FWD_WE, FWD_RDY, LU_DONE, LU_RD,
        input  BRANCH, BRANCH_TYPE, BRANCH_ARG1, BRANCH_ARG2,
        output FWD_A_SEL, FWD_B_SEL, STALL, BRANCH_TAKEN, FLUSH, STALL_CYCLES
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside decode: multi-stage RAW forwarding, load-use and long-op scoreboard stalls,
// branch resolution with a multi-cycle registered flush, and a saturating stall-cycle counter.
module hazard_scoreboard #(
    parameter int XLEN         = 32,
    parameter int FWD_STAGES   = 2,
    parameter int LU_MAX       = 4,
    parameter int FLUSH_CYCLES = 1,
    parameter int SELW         = $clog2(FWD_STAGES + 2)
) (
    input  logic              CLK,
    input  logic              RST,
    hazard_scoreboard_if.slave hz
);
    localparam int OUTW = $clog2(LU_MAX + 1);
    localparam int FCW  = $clog2(FLUSH_CYCLES + 1);
    localparam logic [SELW-1:0] SEL_LU = SELW'(FWD_STAGES + 1);

    logic [31:0]     pending;
    logic [31:0]     pending_nxt;
    logic [OUTW-1:0] outstanding;
    logic [FCW-1:0]  flush_cnt;
    logic [FCW-1:0]  flush_cnt_nxt;
    logic            flush_q;
    logic [31:0]     stall_cycles;

    logic            dv;
    logic [SELW-1:0] sel_a;
    logic [SELW-1:0] sel_b;
    logic            stall_a;
    logic            stall_b;
    logic            stall_waw;
    logic            stall_struct;
    logic            stall;
    logic            cond;
    logic            taken;
    logic            issue;

    // Returns {stall, select} for one source operand. Stages are scanned far-to-near so the
    // nearest matching stage overrides; the long-unit bypass applies only without a stage match.
    function automatic logic [SELW:0] resolve_src(
        input logic                    used,
        input logic [4:0]              rs,
        input logic [5*FWD_STAGES-1:0] fwd_rd,
        input logic [FWD_STAGES-1:0]   fwd_we,
        input logic [FWD_STAGES-1:0]   fwd_rdy,
        input logic [31:0]             pend,
        input logic                    lu_done,
        input logic [4:0]              lu_rd
    );
        logic [SELW-1:0] sel;
        logic            stl;
        logic            hit;
        sel = '0;
        stl = 1'b0;
        hit = 1'b0;
        if (used && rs != 5'd0) begin
            for (int k = FWD_STAGES; k >= 1; k--) begin
                if (fwd_we[k-1] && fwd_rd[5*k-1 -: 5] == rs) begin
                    hit = 1'b1;
                    sel = SELW'(k);
                    stl = !fwd_rdy[k-1];
                end
            end
            if (!hit && pend[rs]) begin
                if (lu_done && lu_rd == rs) begin
                    sel = SEL_LU;
                end else begin
                    stl = 1'b1;
                end
            end
        end
        return {stl, sel};
    endfunction

    always_comb begin
        dv = hz.DE_VALID && !flush_q;
        {stall_a, sel_a} = resolve_src(hz.RS1_USED, hz.RS1, hz.FWD_RD, hz.FWD_WE, hz.FWD_RDY,
                                       pending, hz.LU_DONE, hz.LU_RD);
        {stall_b, sel_b} = resolve_src(hz.RS2_USED, hz.RS2, hz.FWD_RD, hz.FWD_WE, hz.FWD_RDY,
                                       pending, hz.LU_DONE, hz.LU_RD);
        stall_waw = hz.RD_WE && (hz.RD != 5'd0) && pending[hz.RD]
                    && !(hz.LU_DONE && hz.LU_RD == hz.RD);
        stall_struct = hz.LONG_OP && (outstanding == OUTW'(LU_MAX)) && !hz.LU_DONE;
        stall = dv && (stall_a || stall_b || stall_waw || stall_struct);
    end

    always_comb begin
        case (hz.BRANCH_TYPE)
            3'd0:    cond = hz.BRANCH_ARG1 == hz.BRANCH_ARG2;
            3'd1:    cond = hz.BRANCH_ARG1 != hz.BRANCH_ARG2;
            3'd2:    cond = $signed(hz.BRANCH_ARG1) <  $signed(hz.BRANCH_ARG2);
            3'd3:    cond = $signed(hz.BRANCH_ARG1) >= $signed(hz.BRANCH_ARG2);
            3'd4:    cond = hz.BRANCH_ARG1 <  hz.BRANCH_ARG2;
            3'd5:    cond = hz.BRANCH_ARG1 >= hz.BRANCH_ARG2;
            default: cond = 1'b0;
        endcase
        taken = dv && !stall && hz.BRANCH && cond;
        issue = dv && !stall && hz.LONG_OP && hz.RD_WE && (hz.RD != 5'd0);
    end

    // Clear before set so an issue and a completion on the same register leave it pending.
    always_comb begin
        pending_nxt = pending;
        if (hz.LU_DONE) begin
            pending_nxt[hz.LU_RD] = 1'b0;
        end
        if (issue) begin
            pending_nxt[hz.RD] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_comb begin
        flush_cnt_nxt = flush_cnt;
        if (taken) begin
            flush_cnt_nxt = FCW'(FLUSH_CYCLES);
        end else if (flush_cnt != '0) begin
            flush_cnt_nxt = flush_cnt - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending      <= '0;
            outstanding  <= '0;
            flush_cnt    <= '0;
            flush_q      <= 1'b0;
            stall_cycles <= '0;
        end else begin
            pending   <= pending_nxt;
            flush_cnt <= flush_cnt_nxt;
            flush_q   <= (flush_cnt_nxt != '0);
            case ({issue, hz.LU_DONE})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   if (outstanding != '0) outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            if (stall && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 1'b1;
            end
        end
    end

    assign hz.FWD_A_SEL    = dv ? sel_a : '0;
    assign hz.FWD_B_SEL    = dv ? sel_b : '0;
    assign hz.STALL        = stall;
    assign hz.BRANCH_TAKEN = taken;
    assign hz.FLUSH        = flush_q;
    assign hz.STALL_CYCLES = stall_cycles;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed decode scenarios, a per-cycle reference model
// of the hazard rules, and literal spot checks at key points of each scenario.
module tb_hazard_scoreboard;
    localparam int XLEN = 32;
    localparam int FS   = 2;
    localparam int LUM  = 4;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.XLEN(XLEN), .FWD_STAGES(FS)) hz();

    hazard_scoreboard #(
        .XLEN(XLEN), .FWD_STAGES(FS), .LU_MAX(LUM), .FLUSH_CYCLES(FC)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .hz(hz)
    );

    int     n_checks = 0;
    int     n_pass   = 0;
    bit     m_valid  = 1'b0;
    bit     m_pend[32];
    int     m_out;
    int     m_flush;
    longint m_stalls;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference resolution of one source: nearest stage match first, then the scoreboard.
    function automatic void src_model(input bit used, input int rs, output int sel, output bit stl);
        sel = 0;
        stl = 1'b0;
        if (!used || rs == 0) return;
        for (int k = 1; k <= FS; k++) begin
            if (hz.FWD_WE[k-1] && int'(hz.FWD_RD[5*k-1 -: 5]) == rs) begin
                sel = k;
                stl = !hz.FWD_RDY[k-1];
                return;
            end
        end
        if (m_pend[rs]) begin
            if (hz.LU_DONE && int'(hz.LU_RD) == rs) sel = FS + 1;
            else stl = 1'b1;
        end
    endfunction

    function automatic bit br_cond(input int t, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = int'(a);
        sb = int'(b);
        case (t)
            0: return a == b;
            1: return a != b;
            2: return sa < sb;
            3: return sa >= sb;
            4: return a < b;
            5: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    initial begin : compare
        int sa, sb;
        bit sta, stb, dv, st, tk, iss;
        forever begin
            @(negedge clk);
            dv = hz.DE_VALID && (m_flush == 0);
            src_model(hz.RS1_USED, int'(hz.RS1), sa, sta);
            src_model(hz.RS2_USED, int'(hz.RS2), sb, stb);
            st = dv && (sta || stb
                 || (hz.RD_WE && hz.RD != 0 && m_pend[hz.RD] && !(hz.LU_DONE && hz.LU_RD == hz.RD))
                 || (hz.LONG_OP && m_out == LUM && !hz.LU_DONE));
            tk  = dv && !st && hz.BRANCH && br_cond(int'(hz.BRANCH_TYPE), hz.BRANCH_ARG1, hz.BRANCH_ARG2);
            iss = dv && !st && hz.LONG_OP && hz.RD_WE && hz.RD != 0;
            if (!dv) begin
                sa = 0;
                sb = 0;
            end
            if (m_valid) begin
                chk("fwd_a_sel", hz.FWD_A_SEL, sa);
                chk("fwd_b_sel", hz.FWD_B_SEL, sb);
                chk("stall", hz.STALL, st);
                chk("branch_taken", hz.BRANCH_TAKEN, tk);
                chk("flush", hz.FLUSH, m_flush != 0);
                chk("stall_cycles", hz.STALL_CYCLES, m_stalls);
            end
            if (rst) begin
                foreach (m_pend[i]) m_pend[i] = 1'b0;
                m_out    = 0;
                m_flush  = 0;
                m_stalls = 0;
                m_valid  = 1'b1;
            end else if (m_valid) begin
                if (hz.LU_DONE) m_pend[hz.LU_RD] = 1'b0;
                if (iss) m_pend[hz.RD] = 1'b1;
                if (iss && !hz.LU_DONE) m_out++;
                else if (!iss && hz.LU_DONE && m_out > 0) m_out--;
                if (tk) m_flush = FC;
                else if (m_flush > 0) m_flush--;
                if (st && m_stalls < 64'hFFFF_FFFF) m_stalls++;
            end
        end
    end

    task automatic clear_in();
        hz.DE_VALID = 0; hz.RS1 = 0; hz.RS2 = 0; hz.RS1_USED = 0; hz.RS2_USED = 0;
        hz.RD = 0; hz.RD_WE = 0; hz.LONG_OP = 0; hz.FWD_RD = '0; hz.FWD_WE = '0;
        hz.FWD_RDY = '0; hz.LU_DONE = 0; hz.LU_RD = 0; hz.BRANCH = 0; hz.BRANCH_TYPE = 0;
        hz.BRANCH_ARG1 = '0; hz.BRANCH_ARG2 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_in();
    endtask

    task automatic long_op(input logic [4:0] rd);
        hz.DE_VALID = 1; hz.LONG_OP = 1; hz.RD = rd; hz.RD_WE = 1;
    endtask

    task automatic branch(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
        hz.DE_VALID = 1; hz.BRANCH = 1; hz.BRANCH_TYPE = t; hz.BRANCH_ARG1 = a; hz.BRANCH_ARG2 = b;
    endtask

    initial begin
        clear_in();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        chk("rst_flush", hz.FLUSH, 0);
        chk("rst_stall_cycles", hz.STALL_CYCLES, 0);

        // Nearest stage wins, then the farther one when only it matches.
        next_cycle();
        hz.DE_VALID = 1; hz.RS1 = 5; hz.RS1_USED = 1;
        hz.FWD_WE = 2'b11; hz.FWD_RD = {5'd5, 5'd5}; hz.FWD_RDY = 2'b11;
        #2; chk("both_stages_sel", hz.FWD_A_SEL, 1); chk("both_stages_stall", hz.STALL, 0);
        next_cycle();
        hz.DE_VALID = 1; hz.RS1 = 5; hz.RS1_USED = 1;
        hz.FWD_WE = 2'b10; hz.FWD_RD = {5'd5, 5'd5}; hz.FWD_RDY = 2'b11;
        #2; chk("stage2_sel", hz.FWD_A_SEL, 2);

        // x0 never forwards or stalls.
        next_cycle();
        hz.DE_VALID = 1; hz.RS1 = 0; hz.RS1_USED = 1; hz.RD = 0; hz.RD_WE = 1;
        hz.FWD_WE = 2'b01; hz.FWD_RD = 10'd0; hz.FWD_RDY = 2'b00;
        #2; chk("x0_sel", hz.FWD_A_SEL, 0); chk("x0_stall", hz.STALL, 0);

        // Load-use on x7 for two cycles, then the load result shows up in stage 2.
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            hz.DE_VALID = 1; hz.RS2 = 7; hz.RS2_USED = 1;
            hz.FWD_WE = 2'b01; hz.FWD_RD = {5'd0, 5'd7}; hz.FWD_RDY = 2'b00;
            #2; chk("load_use_stall", hz.STALL, 1); chk("load_use_count", hz.STALL_CYCLES, i);
        end
        next_cycle();
        hz.DE_VALID = 1; hz.RS2 = 7; hz.RS2_USED = 1;
        hz.FWD_WE = 2'b10; hz.FWD_RD = {5'd7, 5'd0}; hz.FWD_RDY = 2'b11;
        #2; chk("load_done_sel", hz.FWD_B_SEL, 2); chk("load_done_stall", hz.STALL, 0);
        chk("load_done_count", hz.STALL_CYCLES, 2);

        // Long op to x9, dependent read stalls until completion bypass.
        next_cycle(); long_op(5'd9);
        #2; chk("issue_x9_stall", hz.STALL, 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); hz.DE_VALID = 1; hz.RS1 = 9; hz.RS1_USED = 1;
            #2; chk("wait_x9_stall", hz.STALL, 1);
        end
        next_cycle(); hz.DE_VALID = 1; hz.RS1 = 9; hz.RS1_USED = 1; hz.LU_DONE = 1; hz.LU_RD = 9;
        #2; chk("bypass_x9_sel", hz.FWD_A_SEL, 3); chk("bypass_x9_stall", hz.STALL, 0);
        next_cycle(); hz.DE_VALID = 1; hz.RS1 = 9; hz.RS1_USED = 1;
        #2; chk("x9_clear_stall", hz.STALL, 0); chk("x9_clear_sel", hz.FWD_A_SEL, 0);
        chk("x9_count", hz.STALL_CYCLES, 4);

        // Fill the long unit, then a fifth issue needs a same-cycle completion.
        for (int r = 10; r <= 13; r++) begin
            next_cycle(); long_op(5'(r));
            #2; chk("fill_stall", hz.STALL, 0);
        end
        next_cycle(); long_op(5'd14);
        #2; chk("full_stall", hz.STALL, 1);
        next_cycle(); long_op(5'd14); hz.LU_DONE = 1; hz.LU_RD = 10;
        #2; chk("full_done_stall", hz.STALL, 0);
        next_cycle(); long_op(5'd15);
        #2; chk("still_full_stall", hz.STALL, 1);
        next_cycle(); hz.DE_VALID = 1; hz.RS1 = 10; hz.RS1_USED = 1;
        #2; chk("x10_free", hz.STALL, 0);
        next_cycle(); hz.DE_VALID = 1; hz.RS2 = 14; hz.RS2_USED = 1;
        #2; chk("x14_pending", hz.STALL, 1);
        next_cycle(); hz.DE_VALID = 1; hz.RD = 11; hz.RD_WE = 1;
        #2; chk("waw_stall", hz.STALL, 1);
        for (int r = 11; r <= 14; r++) begin
            next_cycle(); hz.LU_DONE = 1; hz.LU_RD = 5'(r);
        end

        // Taken BEQ, a branch during the flush is ignored, then the flush ends.
        next_cycle(); branch(3'd0, 32'h10, 32'h10);
        #2; chk("beq_taken", hz.BRANCH_TAKEN, 1); chk("beq_no_flush_yet", hz.FLUSH, 0);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); branch(3'd0, 32'h10, 32'h10);
            #2; chk("flush_high", hz.FLUSH, 1); chk("flush_ignores_branch", hz.BRANCH_TAKEN, 0);
        end
        next_cycle(); branch(3'd4, 32'hFFFF_FFFF, 32'h1);
        #2; chk("flush_done", hz.FLUSH, 0); chk("bltu_not_taken", hz.BRANCH_TAKEN, 0);

        // Reset in the middle of a flush with x20 pending.
        next_cycle(); long_op(5'd20);
        next_cycle(); branch(3'd2, 32'hFFFF_FFFF, 32'h1);
        #2; chk("blt_taken", hz.BRANCH_TAKEN, 1);
        next_cycle(); rst = 1'b1;
        #2; chk("pre_rst_flush", hz.FLUSH, 1);
        next_cycle(); rst = 1'b0; hz.DE_VALID = 1; hz.RS1 = 20; hz.RS1_USED = 1;
        #2; chk("post_rst_flush", hz.FLUSH, 0); chk("post_rst_count", hz.STALL_CYCLES, 0);
        chk("post_rst_x20", hz.STALL, 0);

        next_cycle(); branch(3'd5, 32'hFFFF_FFFF, 32'h1);
        #2; chk("bgeu_taken", hz.BRANCH_TAKEN, 1);
        repeat (4) next_cycle();
        @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised second-generation hazard unit for the pipelined OTTER core, sitting beside decode. It resolves RAW forwarding across a configurable number of downstream stages and detects load-use hazards. It also tracks outstanding writes from a variable-latency long-op unit (MUL/DIV) in a per-register scoreboard, resolves branches, and drives a multi-cycle registered flush. A saturating stall-cycle counter is provided for performance monitoring.

## Interface
Parameters:
- XLEN, 32, datapath width of branch operands
- FWD_STAGES, 2, number of forwarding source stages (stage 1 = nearest to decode)
- LU_MAX, 4, maximum outstanding long-unit operations
- FLUSH_CYCLES, 1, cycles FLUSH stays high after a taken branch (≥1)
- SELW, $clog2(FWD_STAGES+2), forward-select width

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- DE_VALID  in  1  decode holds a valid instruction
- RS1, RS2  in  5 each  decode source registers
- RS1_USED, RS2_USED  in  1 each  source actually read
- RD  in  5  decode destination
- RD_WE  in  1  decode writes RD
- LONG_OP  in  1  decode instruction issues to the long unit
- FWD_RD  in  5*FWD_STAGES  destination per stage, stage k at [5k-1:5k-5]
- FWD_WE  in  FWD_STAGES  stage k writes a register
- FWD_RDY  in  FWD_STAGES  stage k result is available for forwarding (0 for load not yet returned)
- LU_DONE  in  1  long unit completes this cycle
- LU_RD  in  5  destination of completing long op
- BRANCH  in  1  decode is a conditional branch
- BRANCH_TYPE  in  3  0 BEQ, 1 BNE, 2 BLT, 3 BGE, 4 BLTU, 5 BGEU, 6/7 never taken
- BRANCH_ARG1, BRANCH_ARG2  in  XLEN each  forwarded branch operands
- FWD_A_SEL, FWD_B_SEL  out  SELW each  0 regfile, k stage k, FWD_STAGES+1 long-unit result
- STALL  out  1  hold fetch/decode, bubble into execute
- BRANCH_TAKEN  out  1  redirect PC
- FLUSH  out  1  squash fetch/decode (registered)
- STALL_CYCLES  out  32  saturating count of stalled cycles

## Operation
- Effective valid: dv = DE_VALID && !FLUSH. All hazard/branch logic is gated by dv; when dv=0, STALL=0, BRANCH_TAKEN=0, selects=0.
- Forward match per source s (RS1/RS2): considered only if RSx_USED and RSx≠0. Lowest k with FWD_WE[k] && FWD_RD[k]==RSx wins: sel=k; if FWD_RDY[k]=0, raise load-use stall. If there is no stage match and pending[RSx]: if LU_DONE && LU_RD==RSx, sel=FWD_STAGES+1; otherwise stall.
- WAW stall: RD_WE && RD≠0 && pending[RD] && !(LU_DONE && LU_RD==RD).
- Structural stall: LONG_OP && outstanding==LU_MAX && !LU_DONE.
- STALL = OR of all stall terms.
- Issue: dv && !STALL && LONG_OP && RD_WE && RD≠0 sets pending[RD] and increments outstanding.
- LU_DONE clears pending[LU_RD] and decrements outstanding (saturating at 0). Simultaneous issue and done leaves outstanding unchanged. If both target the same register, set wins.
- Branch: BRANCH_TAKEN = dv && !STALL && BRANCH && cond(BRANCH_TYPE). BLT/BGE are signed; BLTU/BGEU are unsigned. A not-taken branch causes no flush.
- Flush counter: on BRANCH_TAKEN it loads FLUSH_CYCLES; otherwise it decrements while nonzero. FLUSH = (counter≠0).
- STALL_CYCLES increments when STALL=1 and saturates at 32'hFFFF_FFFF.
- Reset: pending all 0, outstanding 0, flush counter 0 (FLUSH=0), STALL_CYCLES 0. Combinational outputs follow their inputs.

## Timing
- FWD_*_SEL, STALL, BRANCH_TAKEN are combinational, valid in the same cycle.
- Scoreboard set/clear becomes visible in the cycle after the edge. A same-cycle LU_DONE is bypassed combinationally as defined above.
- A taken branch in cycle N gives FLUSH=1 in cycles N+1 .. N+FLUSH_CYCLES. Decode is ignored throughout, so no nested branch can occur.
- RST asserted mid-flush or mid-stall: FLUSH=0, STALL_CYCLES=0, and scoreboard clear on the next cycle.
- Register x0 is never pending, never forwarded, and never stalls.

## Test plan
- FWD_STAGES=2, stage1 and stage2 both write x5 (RDY=1), RS1=x5 -> FWD_A_SEL=1, STALL=0. Stage2 only -> FWD_A_SEL=2.
- Stage1 writes x7 with FWD_RDY[1]=0, RS2=x7 -> STALL=1, STALL_CYCLES increments by 1 per cycle. Next cycle the match moves to stage2 with RDY=1 -> FWD_B_SEL=2, STALL=0.
- Long op issues to x9. Next instruction reads x9 -> STALL held until LU_DONE with LU_RD=9; in that cycle FWD_A_SEL=FWD_STAGES+1 and STALL=0. The following cycle pending[9]=0.
- LU_MAX=4: issue 4 long ops with no completion, then a 5th LONG_OP -> STALL=1. Assert LU_DONE in the same cycle -> issue proceeds and outstanding stays 4.
- FLUSH_CYCLES=2, BEQ with args 0x10/0x10 -> BRANCH_TAKEN=1. FLUSH=1 for exactly 2 cycles, and a BRANCH presented during the flush is ignored. BLTU 0xFFFFFFFF vs 1 -> not taken; BLT -> taken.
- Assert RST during the flush with pending bits set -> next cycle FLUSH=0, STALL_CYCLES=0, and a read of a previously pending register gives STALL=0.
